// File: rtl/player_lives_fsm.sv
// Bomberman life tracking: hit-box overlap latching, lives, post-hit
// invulnerability with sprite blink, and game-over/restart.
module player_lives_fsm #(
  parameter int unsigned LIVES_INIT     = 3,
  parameter int unsigned INVULN_MAX     = 200000000,
  parameter int unsigned BLINK_BIT      = 23,
  parameter int unsigned BM_HB_OFFSET_9 = 8,
  parameter int unsigned BM_HB_SIZE     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_on,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic [9:0] x_b,
  input  logic [9:0] y_b,
  input  logic       exp_on,
  input  logic       enemy_on,
  input  logic       frame_tick,
  input  logic       restart,
  output logic [1:0] lives,
  output logic       gameover,
  output logic       hit_pulse,
  output logic       invuln_active,
  output logic       bm_blink
);

  localparam int unsigned CW_RAW =
    (INVULN_MAX > 1) ? $clog2(INVULN_MAX) : 1;
  localparam int unsigned CNT_W =
    (CW_RAW > BLINK_BIT) ? CW_RAW : BLINK_BIT + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INVULN_MAX - 1);
  localparam logic [10:0] HB_OFF = 11'(BM_HB_OFFSET_9);
  localparam logic [10:0] HB_SZ  = 11'(BM_HB_SIZE);
  localparam logic [1:0]  LIVES_RST = 2'(LIVES_INIT);

  typedef enum logic [1:0] {
    ALIVE    = 2'd0,
    INVULN   = 2'd1,
    GAMEOVER = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             exp_latch;
  logic             enemy_latch;

  logic [10:0] x_w;
  logic [10:0] y_w;
  logic [10:0] xb_w;
  logic [10:0] yb_w;
  logic        in_hb;

  // 11-bit compare so a sprite near the right/bottom edge cannot wrap
  assign x_w  = {1'b0, x};
  assign y_w  = {1'b0, y};
  assign xb_w = {1'b0, x_b};
  assign yb_w = {1'b0, y_b};

  assign in_hb = video_on
               & (x_w >= xb_w)
               & (x_w <  xb_w + HB_SZ)
               & (y_w >= yb_w + HB_OFF)
               & (y_w <  yb_w + HB_OFF + HB_SZ);

  assign bm_blink = (state == INVULN) ? ~cnt[BLINK_BIT] : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ALIVE;
      cnt           <= '0;
      exp_latch     <= 1'b0;
      enemy_latch   <= 1'b0;
      lives         <= LIVES_RST;
      gameover      <= 1'b0;
      hit_pulse     <= 1'b0;
      invuln_active <= 1'b0;
    end else begin
      hit_pulse <= 1'b0;

      if (frame_tick) begin
        exp_latch   <= 1'b0;
        enemy_latch <= 1'b0;
      end else begin
        if (in_hb & exp_on)   exp_latch   <= 1'b1;
        if (in_hb & enemy_on) enemy_latch <= 1'b1;
      end

      unique case (state)
        ALIVE: begin
          if (frame_tick & (exp_latch | enemy_latch)) begin
            hit_pulse <= 1'b1;
            if (lives > 2'd1) begin
              lives         <= lives - 2'd1;
              cnt           <= '0;
              state         <= INVULN;
              invuln_active <= 1'b1;
            end else begin
              lives    <= 2'd0;
              state    <= GAMEOVER;
              gameover <= 1'b1;
            end
          end
        end
        INVULN: begin
          if (cnt == CNT_LAST) begin
            cnt           <= '0;
            state         <= ALIVE;
            invuln_active <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAMEOVER: begin
          if (restart) begin
            lives         <= LIVES_RST;
            cnt           <= '0;
            state         <= INVULN;
            gameover      <= 1'b0;
            invuln_active <= 1'b1;
          end
        end
        default: begin
          state <= ALIVE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_lives_fsm.sv
// Scoreboard bench for player_lives_fsm: directed scenarios plus
// randomized frames, checked against a frame-level behavioural model.
module tb_player_lives_fsm;

  localparam int INV_MAX = 100;
  localparam int BLINK_PERIOD = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       video_on = 1'b0;
  logic [9:0] x = '0;
  logic [9:0] y = '0;
  logic [9:0] x_b = '0;
  logic [9:0] y_b = '0;
  logic       exp_on = 1'b0;
  logic       enemy_on = 1'b0;
  logic       frame_tick = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] lives;
  logic       gameover;
  logic       hit_pulse;
  logic       invuln_active;
  logic       bm_blink;

  player_lives_fsm #(
    .LIVES_INIT(3),
    .INVULN_MAX(INV_MAX),
    .BLINK_BIT(3),
    .BM_HB_OFFSET_9(8),
    .BM_HB_SIZE(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .video_on(video_on),
    .x(x),
    .y(y),
    .x_b(x_b),
    .y_b(y_b),
    .exp_on(exp_on),
    .enemy_on(enemy_on),
    .frame_tick(frame_tick),
    .restart(restart),
    .lives(lives),
    .gameover(gameover),
    .hit_pulse(hit_pulse),
    .invuln_active(invuln_active),
    .bm_blink(bm_blink)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] lives;
    logic       gameover;
    logic       hit_pulse;
    logic       invuln_active;
    logic       bm_blink;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model: lives count, game-over flag, cycles spent invulnerable,
  // and whether any overlap was seen since the last frame tick.
  int m_lives = 3;
  bit m_over = 0;
  bit m_inv = 0;
  int m_elapsed = 0;
  bit m_pend = 0;
  bit m_pulse = 0;

  task automatic step(input bit rst, input bit vo,
                      input int px, input int py,
                      input bit ex, input bit en,
                      input bit ft, input bit rs);
    int  xi, yi, xbi, ybi;
    bit  hb;
    exp_t e;
    @(negedge clk);
    reset = rst; video_on = vo;
    x = 10'(px); y = 10'(py);
    exp_on = ex; enemy_on = en;
    frame_tick = ft; restart = rs;
    xi = int'(x); yi = int'(y);
    xbi = int'(x_b); ybi = int'(y_b);
    hb = vo && xi >= xbi && xi < xbi + 16 &&
         yi >= ybi + 8 && yi < ybi + 24;
    m_pulse = 0;
    if (rst) begin
      m_lives = 3; m_over = 0; m_inv = 0;
      m_elapsed = 0; m_pend = 0;
    end else begin
      if (m_inv) begin
        if (m_elapsed == INV_MAX - 1) begin
          m_inv = 0; m_elapsed = 0;
        end else begin
          m_elapsed++;
        end
      end else if (m_over) begin
        if (rs) begin
          m_lives = 3; m_over = 0;
          m_inv = 1; m_elapsed = 0;
        end
      end else if (ft && m_pend) begin
        m_pulse = 1;
        if (m_lives > 1) begin
          m_lives--; m_inv = 1; m_elapsed = 0;
        end else begin
          m_lives = 0; m_over = 1;
        end
      end
      if (ft) m_pend = 0;
      else if (hb && (ex || en)) m_pend = 1;
    end
    e.lives = 2'(m_lives);
    e.gameover = m_over;
    e.hit_pulse = m_pulse;
    e.invuln_active = m_inv;
    e.bm_blink = m_inv ? ((m_elapsed / BLINK_PERIOD) % 2 == 0) : 1'b1;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input bit ft);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, ft, 0);
  endtask

  // Monitor: compares every registered output cycle with the model.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({lives, gameover, hit_pulse, invuln_active, bm_blink} !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got lives=%0d go=%b hp=%b inv=%b blink=%b exp lives=%0d go=%b hp=%b inv=%b blink=%b",
                 $time, lives, gameover, hit_pulse, invuln_active, bm_blink,
                 e.lives, e.gameover, e.hit_pulse, e.invuln_active, e.bm_blink);
      end
    end
  end

  initial begin
    int px, py;
    bit rst;
    x_b = 10'd100; y_b = 10'd200;
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Hit inside box, then tick
    step(0, 1, 105, 215, 1, 0, 0, 0);
    idle(1, 1);
    idle(3, 0);
    // Overlap and tick during invulnerability are ignored
    step(0, 1, 105, 215, 1, 0, 0, 0);
    idle(1, 1);
    idle(110, 0);

    // Just outside the box on the right
    step(0, 1, 116, 215, 1, 0, 0, 0);
    idle(1, 1);
    step(0, 1, 104, 207, 0, 1, 0, 0);
    step(0, 1, 104, 224, 0, 1, 0, 0);
    step(0, 1, 99, 215, 1, 1, 0, 0);
    step(0, 0, 105, 215, 1, 1, 0, 0);
    idle(1, 1);

    // Explosion and enemy in one frame: one hit
    step(0, 1, 100, 208, 1, 1, 0, 0);
    step(0, 1, 115, 223, 1, 1, 0, 0);
    idle(1, 1);
    idle(105, 0);

    // Final hit to game over, then restart
    step(0, 1, 110, 220, 0, 1, 0, 0);
    idle(1, 1);
    idle(4, 0);
    step(0, 1, 0, 0, 0, 0, 0, 1);
    idle(110, 0);

    // Reset mid-invulnerability with tick and a set latch
    step(0, 1, 105, 215, 1, 0, 0, 0);
    idle(1, 1);
    idle(49, 0);
    step(0, 1, 105, 215, 1, 0, 0, 0);
    step(1, 1, 105, 215, 1, 0, 1, 0);
    idle(1, 1);
    idle(3, 0);

    // Edge-of-screen box: no wrap in the compare
    x_b = 10'd1015; y_b = 10'd1000;
    step(0, 1, 1023, 1010, 1, 0, 0, 0);
    idle(1, 1);
    idle(110, 0);

    for (int c = 0; c < 6000; c++) begin
      if (c % 600 == 0) begin
        x_b = ($urandom % 4 == 0) ? 10'(1000 + $urandom_range(0, 23))
                                  : 10'($urandom_range(0, 1023));
        y_b = 10'($urandom_range(0, 1010));
      end
      px = (int'(x_b) + int'($urandom_range(0, 24)) - 4) & 1023;
      py = (int'(y_b) + int'($urandom_range(4, 28))) & 1023;
      rst = ($urandom % 1500 == 0);
      step(rst, $urandom % 8 != 0, px, py,
           $urandom % 4 == 0, $urandom % 6 == 0,
           $urandom % 12 == 0, $urandom % 40 == 0);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending need 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_lives_fsm.md
Name: player_lives_fsm

Overview:
Downstream consumer of the bomb stage's explosion pixel flag (exp_on) and of the enemy pixel flag. Per frame, it detects overlap between an explosion or enemy pixel and the bomberman 16x16 hit box. It decrements the life counter, runs a post-hit invulnerability window with a sprite-blink output, and drives gameover back to the bomb stage and bomberman movement logic.

Parameters:
LIVES_INIT, 3, lives loaded at reset and at restart (1..3; fits 2 bits)
INVULN_MAX, 200000000, invulnerability duration in clk cycles (2 s at 100 MHz)
BLINK_BIT, 23, invuln counter bit that drives bm_blink
BM_HB_OFFSET_9, 8, sprite top to hit box top, in pixels
BM_HB_SIZE, 16, hit box side length, in pixels

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
video_on  in  1  visible-area flag from the VGA sync
x  in  10  current screen pixel x
y  in  10  current screen pixel y
x_b  in  10  bomberman sprite x, screen coordinates
y_b  in  10  bomberman sprite y, screen coordinates
exp_on  in  1  explosion tile covers the current pixel (bomb stage)
enemy_on  in  1  enemy sprite covers the current pixel
frame_tick  in  1  one-cycle pulse once per frame, during vertical blank
restart  in  1  player restart request (level or pulse)
lives  out  2  remaining lives
gameover  out  1  high while in GAMEOVER
hit_pulse  out  1  one-cycle pulse on each accepted hit
invuln_active  out  1  high while in INVULN
bm_blink  out  1  sprite visibility gate: 1 = draw bomberman

Behaviour:
- Single clock domain. All state changes on the rising edge of clk. Reset is synchronous and active-high.
- Reset values: lives = LIVES_INIT, gameover = 0, hit_pulse = 0, invuln_active = 0, bm_blink = 1, state = ALIVE, invuln counter = 0, both hit latches = 0.
- Hit box test, computed combinationally in 11-bit arithmetic so there is no wrap:
  - in_hb = video_on & (x >= x_b) & (x < x_b + BM_HB_SIZE) & (y >= y_b + BM_HB_OFFSET_9) & (y < y_b + BM_HB_OFFSET_9 + BM_HB_SIZE).
- Hit latches:
  - exp_latch is set on the edge after any cycle with in_hb & exp_on.
  - enemy_latch is set on the edge after any cycle with in_hb & enemy_on.
  - Both latches clear on the edge at which frame_tick = 1, in every state. Clear takes priority over a same-cycle set.
- FSM states: ALIVE, INVULN, GAMEOVER.
- ALIVE, on a cycle with frame_tick = 1 and (exp_latch | enemy_latch):
  - hit_pulse = 1 for exactly the next cycle.
  - If lives > 1: lives decrements by 1, state goes to INVULN, counter is cleared to 0.
  - If lives == 1: lives becomes 0, state goes to GAMEOVER.
  - With frame_tick = 1 and no latch set, nothing changes.
- INVULN:
  - Counter increments every cycle.
  - When counter == INVULN_MAX-1, state goes to ALIVE and counter goes to 0.
  - Hits are ignored; latches are still cleared at every frame_tick.
  - invuln_active = 1 throughout; bm_blink = ~counter[BLINK_BIT].
- GAMEOVER:
  - gameover = 1, lives = 0, bm_blink = 1, invuln_active = 0.
  - restart = 1 loads lives = LIVES_INIT, clears the counter and moves to INVULN (grace period).
  - restart is ignored in ALIVE and INVULN.
- Latency: lives, gameover and hit_pulse update on the edge after the frame_tick cycle, so they are visible 1 cycle after the tick.
- Simultaneous events:
  - Explosion and enemy in the same frame count as one hit.
  - Reset asserted in any state overrides everything, including a concurrent frame_tick.
- Outside ALIVE, hit_pulse is never asserted.
- All outputs are registered except bm_blink, which is combinational from the state and the counter register.

Test Plan:
- Sim params INVULN_MAX = 100, BLINK_BIT = 3. Reset, x_b = 100, y_b = 200, then drive exp_on = 1 at pixel (105, 215) with video_on = 1, then frame_tick -> 1 cycle later lives = 2, hit_pulse high 1 cycle, invuln_active = 1.
- Same setup, exp_on only at pixel (116, 215), just outside the hit box, then frame_tick -> lives stays 3, no hit_pulse.
- In INVULN, repeat the exp_on overlap and frame_tick -> lives unchanged. bm_blink toggles every 8 cycles. invuln_active drops exactly 100 cycles after entry, and the state returns to ALIVE.
- Three hits, each separated by a completed INVULN window -> lives 3→2→1→0, gameover = 1 one cycle after the third tick. restart pulse -> lives = 3, gameover = 0, invuln_active = 1.
- Explosion and enemy overlap in the same frame -> exactly one decrement, one hit_pulse.
- Assert reset mid-INVULN at counter = 50, together with frame_tick and a set latch -> next cycle: lives = 3, state ALIVE, latches 0, counter 0.
